// File: rtl/ghost_mode_scheduler.sv
// Ghost mode scheduler: scatter/chase phase table, frightened mode and house-release flags.
// Optional idle-release timer is enabled by defining GHOST_IDLE_RELEASE_EN.
module ghost_mode_scheduler #(
  parameter int FRAMES_PER_SEC = 60,
  parameter int FRIGHT_SECONDS = 6,
  parameter int INKY_DOTS      = 30,
  parameter int CLYDE_DOTS     = 60
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       level_start,
  input  logic       power_pellet,
  input  logic       dot_eaten,
  input  logic       pacman_dead,
  output logic [1:0] mode,
  output logic [2:0] phase_idx,
  output logic       reverse_req,
  output logic       fright_flash,
  output logic [3:0] ghost_release
);

  typedef enum logic [1:0] {
    MODE_WAIT    = 2'd0,
    MODE_SCATTER = 2'd1,
    MODE_CHASE   = 2'd2,
    MODE_FRIGHT  = 2'd3
  } mode_e;

  localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [FW-1:0] FRAME_LAST  = FW'(FRAMES_PER_SEC - 1);
  localparam logic [6:0]    FRIGHT_LAST = 7'(FRIGHT_SECONDS - 1);
  localparam logic [6:0]    FLASH_FROM  = 7'((FRIGHT_SECONDS > 2) ? FRIGHT_SECONDS - 2 : 0);
  localparam logic [7:0]    INKY_TH     = 8'(INKY_DOTS);
  localparam logic [7:0]    CLYDE_TH    = 8'(CLYDE_DOTS);

`ifdef GHOST_IDLE_RELEASE_EN
  localparam int IDLE_FRAMES = 4 * FRAMES_PER_SEC;
  localparam int IW          = $clog2(IDLE_FRAMES + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_FRAMES - 1);

  logic [IW-1:0] idle_q, idle_d;
  logic          idle_done;
`endif

  mode_e         mode_q, mode_d;
  mode_e         saved_q, saved_d;
  logic [2:0]    phase_q, phase_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [6:0]    sec_q, sec_d;
  logic [FW-1:0] ffrm_q, ffrm_d;
  logic [6:0]    fsec_q, fsec_d;
  logic [7:0]    dots_q, dots_d;
  logic [3:0]    rel_q, rel_d;
  logic          rev_q, rev_d;

  // Last second index of each phase; phase 7 is endless chase.
  function automatic logic [6:0] phase_last(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd2:        phase_last = 7'd6;
      3'd1, 3'd3, 3'd5:  phase_last = 7'd19;
      3'd4, 3'd6:        phase_last = 7'd4;
      default:           phase_last = 7'd127;
    endcase
  endfunction

  always_comb begin
    mode_d  = mode_q;
    saved_d = saved_q;
    phase_d = phase_q;
    frame_d = frame_q;
    sec_d   = sec_q;
    ffrm_d  = ffrm_q;
    fsec_d  = fsec_q;
    dots_d  = dots_q;
    rel_d   = rel_q;
    rev_d   = 1'b0;
`ifdef GHOST_IDLE_RELEASE_EN
    idle_d    = idle_q;
    idle_done = 1'b0;
`endif

    if (pacman_dead) begin
      mode_d  = MODE_WAIT;
      saved_d = MODE_WAIT;
      phase_d = 3'd0;
      frame_d = '0;
      sec_d   = '0;
      ffrm_d  = '0;
      fsec_d  = '0;
      rel_d   = 4'b0000;
`ifdef GHOST_IDLE_RELEASE_EN
      idle_d  = '0;
`endif
    end else begin
      if (dot_eaten && (mode_q != MODE_WAIT) && (dots_q != 8'hFF))
        dots_d = dots_q + 8'd1;

      case (mode_q)
        MODE_WAIT: begin
          if (level_start) begin
            mode_d     = MODE_SCATTER;
            phase_d    = 3'd0;
            frame_d    = '0;
            sec_d      = '0;
            rel_d[1:0] = 2'b11;
          end
        end
        MODE_SCATTER, MODE_CHASE: begin
          // A pellet wins over a phase expiry in the same frame; the counters
          // stay frozen just short of expiry and expire once fright ends.
          if (power_pellet) begin
            saved_d = mode_q;
            mode_d  = MODE_FRIGHT;
            ffrm_d  = '0;
            fsec_d  = '0;
            rev_d   = 1'b1;
          end else if (frame_q == FRAME_LAST) begin
            frame_d = '0;
            if ((phase_q != 3'd7) && (sec_q == phase_last(phase_q))) begin
              phase_d = phase_q + 3'd1;
              sec_d   = '0;
              mode_d  = phase_d[0] ? MODE_CHASE : MODE_SCATTER;
              rev_d   = 1'b1;
            end else if (sec_q != 7'd127) begin
              sec_d = sec_q + 7'd1;
            end
          end else begin
            frame_d = frame_q + FW'(1);
          end
        end
        MODE_FRIGHT: begin
          if (power_pellet) begin
            ffrm_d = '0;
            fsec_d = '0;
          end else if (ffrm_q == FRAME_LAST) begin
            ffrm_d = '0;
            if (fsec_q == FRIGHT_LAST) begin
              mode_d = saved_q;
              fsec_d = '0;
            end else begin
              fsec_d = fsec_q + 7'd1;
            end
          end else begin
            ffrm_d = ffrm_q + FW'(1);
          end
        end
        default: mode_d = MODE_WAIT;
      endcase

      // Dot-based release only while the level is live, so a held dot count
      // does not re-release ghosts during the post-death wait.
      if (mode_d != MODE_WAIT) begin
        if (dots_d >= INKY_TH)  rel_d[2] = 1'b1;
        if (dots_d >= CLYDE_TH) rel_d[3] = 1'b1;
      end

`ifdef GHOST_IDLE_RELEASE_EN
      if (dot_eaten || level_start) begin
        idle_d = '0;
      end else if (mode_q != MODE_WAIT) begin
        if (idle_q == IDLE_LAST) begin
          idle_d = '0;
          for (int i = 0; i < 4; i++) begin
            if (!idle_done && !rel_d[i]) begin
              rel_d[i]  = 1'b1;
              idle_done = 1'b1;
            end
          end
        end else begin
          idle_d = idle_q + IW'(1);
        end
      end
`endif
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      mode_q  <= MODE_WAIT;
      saved_q <= MODE_WAIT;
      phase_q <= 3'd0;
      frame_q <= '0;
      sec_q   <= '0;
      ffrm_q  <= '0;
      fsec_q  <= '0;
      dots_q  <= '0;
      rel_q   <= 4'b0000;
      rev_q   <= 1'b0;
`ifdef GHOST_IDLE_RELEASE_EN
      idle_q  <= '0;
`endif
    end else begin
      mode_q  <= mode_d;
      saved_q <= saved_d;
      phase_q <= phase_d;
      frame_q <= frame_d;
      sec_q   <= sec_d;
      ffrm_q  <= ffrm_d;
      fsec_q  <= fsec_d;
      dots_q  <= dots_d;
      rel_q   <= rel_d;
      rev_q   <= rev_d;
`ifdef GHOST_IDLE_RELEASE_EN
      idle_q  <= idle_d;
`endif
    end
  end

  assign mode          = mode_q;
  assign phase_idx     = phase_q;
  assign reverse_req   = rev_q;
  assign fright_flash  = (mode_q == MODE_FRIGHT) && (fsec_q >= FLASH_FROM);
  assign ghost_release = rel_q;

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Directed bench for ghost_mode_scheduler with default parameters (60 fps).
module tb_ghost_mode_scheduler;

  logic       frame_clk;
  logic       Reset;
  logic       level_start;
  logic       power_pellet;
  logic       dot_eaten;
  logic       pacman_dead;
  logic [1:0] mode;
  logic [2:0] phase_idx;
  logic       reverse_req;
  logic       fright_flash;
  logic [3:0] ghost_release;

  int pass_cnt  = 0;
  int total_cnt = 0;

  ghost_mode_scheduler dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .level_start  (level_start),
    .power_pellet (power_pellet),
    .dot_eaten    (dot_eaten),
    .pacman_dead  (pacman_dead),
    .mode         (mode),
    .phase_idx    (phase_idx),
    .reverse_req  (reverse_req),
    .fright_flash (fright_flash),
    .ghost_release(ghost_release)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  // Advance n edges with idle inputs; outputs are sampled 1 time unit after the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge frame_clk);
      #1;
    end
  endtask

  // Hold the given inputs for exactly one edge.
  task automatic step(input logic ls, input logic pp, input logic de, input logic pd);
    level_start  = ls;
    power_pellet = pp;
    dot_eaten    = de;
    pacman_dead  = pd;
    @(posedge frame_clk);
    #1;
    level_start  = 1'b0;
    power_pellet = 1'b0;
    dot_eaten    = 1'b0;
    pacman_dead  = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick(2);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (mode !== 2'd0) $display("FAIL reset_mode got %0d want 0", mode); else pass_cnt++;
    total_cnt++; if (phase_idx !== 3'd0) $display("FAIL reset_phase got %0d want 0", phase_idx); else pass_cnt++;
    total_cnt++; if (reverse_req !== 1'b0) $display("FAIL reset_rev got %0b want 0", reverse_req); else pass_cnt++;
    total_cnt++; if (fright_flash !== 1'b0) $display("FAIL reset_flash got %0b want 0", fright_flash); else pass_cnt++;
    total_cnt++; if (ghost_release !== 4'b0000) $display("FAIL reset_release got %b want 0000", ghost_release); else pass_cnt++;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    total_cnt++; if (mode !== 2'd0 || reverse_req !== 1'b0) $display("FAIL wait_pellet got mode %0d rev %0b want 0 0", mode, reverse_req); else pass_cnt++;
  endtask

  task automatic test_level_start();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    total_cnt++; if (mode !== 2'd1 || phase_idx !== 3'd0) $display("FAIL start_mode got %0d/%0d want 1/0", mode, phase_idx); else pass_cnt++;
    total_cnt++; if (ghost_release !== 4'b0011) $display("FAIL start_release got %b want 0011", ghost_release); else pass_cnt++;
    tick(419);
    total_cnt++; if (mode !== 2'd1 || reverse_req !== 1'b0) $display("FAIL scatter_419 got mode %0d rev %0b want 1 0", mode, reverse_req); else pass_cnt++;
    tick(1);
    total_cnt++; if (mode !== 2'd2 || phase_idx !== 3'd1 || reverse_req !== 1'b1) $display("FAIL phase0_expiry got %0d/%0d/%0b want 2/1/1", mode, phase_idx, reverse_req); else pass_cnt++;
    tick(1);
    total_cnt++; if (reverse_req !== 1'b0) $display("FAIL rev_one_frame got %0b want 0", reverse_req); else pass_cnt++;
  endtask

  task automatic test_fright();
    tick(119);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    total_cnt++; if (mode !== 2'd3 || reverse_req !== 1'b1) $display("FAIL fright_enter got %0d/%0b want 3/1", mode, reverse_req); else pass_cnt++;
    tick(239);
    total_cnt++; if (fright_flash !== 1'b0) $display("FAIL flash_239 got %0b want 0", fright_flash); else pass_cnt++;
    tick(1);
    total_cnt++; if (fright_flash !== 1'b1 || mode !== 2'd3) $display("FAIL flash_240 got %0b mode %0d want 1 3", fright_flash, mode); else pass_cnt++;
    tick(119);
    total_cnt++; if (mode !== 2'd3) $display("FAIL fright_359 got %0d want 3", mode); else pass_cnt++;
    tick(1);
    total_cnt++; if (mode !== 2'd2 || phase_idx !== 3'd1 || reverse_req !== 1'b0 || fright_flash !== 1'b0) $display("FAIL fright_exit got %0d/%0d/%0b/%0b want 2/1/0/0", mode, phase_idx, reverse_req, fright_flash); else pass_cnt++;
    tick(1079);
    total_cnt++; if (mode !== 2'd2 || phase_idx !== 3'd1) $display("FAIL phase1_1079 got %0d/%0d want 2/1", mode, phase_idx); else pass_cnt++;
    tick(1);
    total_cnt++; if (mode !== 2'd1 || phase_idx !== 3'd2 || reverse_req !== 1'b1) $display("FAIL phase1_expiry got %0d/%0d/%0b want 1/2/1", mode, phase_idx, reverse_req); else pass_cnt++;
  endtask

  task automatic test_fright_extend();
    int revs;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    total_cnt++; if (mode !== 2'd3 || reverse_req !== 1'b1) $display("FAIL ext_enter got %0d/%0b want 3/1", mode, reverse_req); else pass_cnt++;
    tick(299);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    total_cnt++; if (mode !== 2'd3 || reverse_req !== 1'b0) $display("FAIL ext_repellet got %0d/%0b want 3/0", mode, reverse_req); else pass_cnt++;
    revs = 0;
    for (int i = 0; i < 359; i++) begin
      tick(1);
      if (reverse_req === 1'b1) revs++;
    end
    total_cnt++; if (mode !== 2'd3 || revs !== 0) $display("FAIL ext_359 got mode %0d revs %0d want 3 0", mode, revs); else pass_cnt++;
    tick(1);
    total_cnt++; if (mode !== 2'd1 || phase_idx !== 3'd2 || reverse_req !== 1'b0) $display("FAIL ext_exit got %0d/%0d/%0b want 1/2/0", mode, phase_idx, reverse_req); else pass_cnt++;
  endtask

  task automatic test_pellet_at_expiry();
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    tick(419);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    total_cnt++; if (mode !== 2'd3 || phase_idx !== 3'd0 || reverse_req !== 1'b1) $display("FAIL coinc_enter got %0d/%0d/%0b want 3/0/1", mode, phase_idx, reverse_req); else pass_cnt++;
    tick(360);
    total_cnt++; if (mode !== 2'd1 || phase_idx !== 3'd0 || reverse_req !== 1'b0) $display("FAIL coinc_restore got %0d/%0d/%0b want 1/0/0", mode, phase_idx, reverse_req); else pass_cnt++;
    tick(1);
    total_cnt++; if (mode !== 2'd2 || phase_idx !== 3'd1 || reverse_req !== 1'b1) $display("FAIL coinc_expiry got %0d/%0d/%0b want 2/1/1", mode, phase_idx, reverse_req); else pass_cnt++;
  endtask

  task automatic test_dots();
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    total_cnt++; if (ghost_release !== 4'b0011) $display("FAIL dots_25 got %b want 0011", ghost_release); else pass_cnt++;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    total_cnt++; if (ghost_release !== 4'b0111) $display("FAIL dots_30 got %b want 0111", ghost_release); else pass_cnt++;
    for (int i = 0; i < 29; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    total_cnt++; if (ghost_release !== 4'b0111) $display("FAIL dots_59 got %b want 0111", ghost_release); else pass_cnt++;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    total_cnt++; if (ghost_release !== 4'b1111) $display("FAIL dots_60 got %b want 1111", ghost_release); else pass_cnt++;
  endtask

  task automatic test_dead_and_pellet();
    step(1'b0, 1'b1, 1'b0, 1'b1);
    total_cnt++; if (mode !== 2'd0 || ghost_release !== 4'b0000 || reverse_req !== 1'b0) $display("FAIL dead_pellet got %0d/%b/%0b want 0/0000/0", mode, ghost_release, reverse_req); else pass_cnt++;
    total_cnt++; if (phase_idx !== 3'd0 || fright_flash !== 1'b0) $display("FAIL dead_phase got %0d/%0b want 0/0", phase_idx, fright_flash); else pass_cnt++;
    tick(1);
    total_cnt++; if (reverse_req !== 1'b0 || mode !== 2'd0) $display("FAIL dead_next got %0b/%0d want 0/0", reverse_req, mode); else pass_cnt++;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    total_cnt++; if (mode !== 2'd1 || ghost_release !== 4'b1111) $display("FAIL dots_held got %0d/%b want 1/1111", mode, ghost_release); else pass_cnt++;
  endtask

  task automatic test_reset_mid_fright();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    tick(250);
    total_cnt++; if (mode !== 2'd3 || fright_flash !== 1'b1) $display("FAIL midfr_pre got %0d/%0b want 3/1", mode, fright_flash); else pass_cnt++;
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    total_cnt++; if (mode !== 2'd0 || fright_flash !== 1'b0 || reverse_req !== 1'b0 || ghost_release !== 4'b0000) $display("FAIL midfr_reset got %0d/%0b/%0b/%b want 0/0/0/0000", mode, fright_flash, reverse_req, ghost_release); else pass_cnt++;
  endtask

`ifdef GHOST_IDLE_RELEASE_EN
  task automatic test_idle_release();
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    tick(239);
    total_cnt++; if (ghost_release !== 4'b0011) $display("FAIL idle_239 got %b want 0011", ghost_release); else pass_cnt++;
    tick(1);
    total_cnt++; if (ghost_release !== 4'b0111) $display("FAIL idle_240 got %b want 0111", ghost_release); else pass_cnt++;
    tick(240);
    total_cnt++; if (ghost_release !== 4'b1111) $display("FAIL idle_480 got %b want 1111", ghost_release); else pass_cnt++;
  endtask
`endif

  initial begin
    Reset        = 1'b1;
    level_start  = 1'b0;
    power_pellet = 1'b0;
    dot_eaten    = 1'b0;
    pacman_dead  = 1'b0;
    test_reset();
    test_level_start();
    test_fright();
    test_fright_extend();
    test_pellet_at_expiry();
    test_dots();
    test_dead_and_pellet();
    test_reset_mid_fright();
`ifdef GHOST_IDLE_RELEASE_EN
    test_idle_release();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ghost_mode_scheduler.md
GHOST_MODE_SCHEDULER -- requirements
Module: ghost_mode_scheduler

Interface
REQ-001 SHALL have parameter FRAMES_PER_SEC, default 60, giving frames per timer second.
REQ-002 SHALL have parameter FRIGHT_SECONDS, default 6, giving frightened duration in seconds.
REQ-003 SHALL have parameter INKY_DOTS, default 30, giving the dot count that releases Inky.
REQ-004 SHALL have parameter CLYDE_DOTS, default 60, giving the dot count that releases Clyde.
REQ-005 SHALL have port frame_clk  in  1  frame clock (~60 Hz); all state updates on its rising edge.
REQ-006 SHALL have port Reset  in  1  reset: synchronous, active-high, sampled on frame_clk.
REQ-007 SHALL have port level_start  in  1  one-frame pulse when Pac-Man first moves.
REQ-008 SHALL have port power_pellet  in  1  one-frame pulse when a power pellet is eaten.
REQ-009 SHALL have port dot_eaten  in  1  one-frame pulse when a normal dot is eaten.
REQ-010 SHALL have port pacman_dead  in  1  one-frame pulse when Pac-Man dies.
REQ-011 SHALL have port mode  out  2  ghost mode: 0 WAIT, 1 SCATTER, 2 CHASE, 3 FRIGHT.
REQ-012 SHALL have port phase_idx  out  3  current scatter/chase phase index, 0..7.
REQ-013 SHALL have port reverse_req  out  1  one-frame pulse telling all ghosts to reverse direction.
REQ-014 SHALL have port fright_flash  out  1  high during the last 2 seconds of FRIGHT.
REQ-015 SHALL have port release  out  4  sticky house-release flags: [0] Blinky, [1] Pinky, [2] Inky, [3] Clyde.

Function
REQ-016 SHALL keep a frame counter (0..FRAMES_PER_SEC-1) and a 7-bit seconds counter; the seconds counter increments when the frame counter wraps.
REQ-017 SHALL run the phase table by phase_idx: 0 S7, 1 C20, 2 S7, 3 C20, 4 S5, 5 C20, 6 S5, 7 C forever (S = SCATTER, C = CHASE, number = seconds).
REQ-018 SHALL move WAIT->SCATTER with phase_idx=0 and timers cleared on level_start; level_start outside WAIT has no effect.
REQ-019 SHALL, when the seconds counter reaches the current phase length: increment phase_idx, clear both counters, switch SCATTER/CHASE and pulse reverse_req for one frame; phase 7 never expires.
REQ-020 SHALL, on power_pellet in SCATTER or CHASE: save the current mode, enter FRIGHT, freeze the phase counters, clear the fright counters and pulse reverse_req.
REQ-021 SHALL, on power_pellet while in FRIGHT: restart the fright counters with no reverse_req pulse; power_pellet in WAIT is ignored.
REQ-022 SHALL, when the fright counter reaches FRIGHT_SECONDS, restore the saved mode and resume the phase counters from their frozen values, with no reverse_req pulse.
REQ-023 SHALL assert fright_flash when mode==FRIGHT and fright seconds >= FRIGHT_SECONDS-2.
REQ-024 SHALL set release[0] and release[1] on level_start.
REQ-025 SHALL keep an 8-bit saturating dot counter, incremented on dot_eaten only when mode != WAIT.
REQ-026 SHALL set release[2] when dots >= INKY_DOTS and release[3] when dots >= CLYDE_DOTS.
REQ-027 SHALL keep release bits set until Reset or pacman_dead.
REQ-028 SHALL, on pacman_dead: go to WAIT, set phase_idx=0, clear timers, release, fright state and reverse_req, and hold the dot counter.
REQ-029 SHALL apply same-frame event priority: Reset > pacman_dead > power_pellet > phase or fright expiry.
REQ-030 SHALL, when a pellet and an expiry occur in the same frame, not advance the phase; the expiry is re-evaluated after FRIGHT ends.
REQ-031 SHALL emit at most one reverse_req pulse per frame.

Reset
REQ-032 SHALL, on Reset, set mode=WAIT, phase_idx=0, reverse_req=0, fright_flash=0 and release=4'b0000.
REQ-033 SHALL, on Reset, clear all counters and the saved mode.
REQ-034 SHALL have Reset take effect mid-FRIGHT or mid-phase on the next edge, with no reverse_req pulse.

Configuration
REQ-035 SHALL, with GHOST_IDLE_RELEASE_EN defined, keep an idle frame counter that clears on dot_eaten and on level_start.
REQ-036 SHALL, with GHOST_IDLE_RELEASE_EN defined, release the lowest-index unreleased ghost when the idle counter reaches 4*FRAMES_PER_SEC frames outside WAIT, then clear the idle counter.
REQ-037 SHALL, with GHOST_IDLE_RELEASE_EN undefined, omit the idle counter so release depends only on level_start and the dot count.

Verification
REQ-038 SHALL cover: Reset, then level_start -> mode=1, phase_idx=0, release=0011; after 420 frames -> mode=2, phase_idx=1, one reverse_req pulse.
REQ-039 SHALL cover: power_pellet 120 frames into phase 1 -> mode=3 and reverse_req; fright_flash at frame 240 of FRIGHT; mode=2 after 360 frames; phase 1 expires 1080 frames later.
REQ-040 SHALL cover: second power_pellet 300 frames into FRIGHT -> FRIGHT extends 360 more frames, with no second reverse_req.
REQ-041 SHALL cover: 30 dot_eaten pulses -> release=0111; 60 pulses -> release=1111; dot_eaten while in WAIT leaves the counter unchanged.
REQ-042 SHALL cover: pacman_dead and power_pellet in the same frame -> mode=0, release=0000, no reverse_req.
REQ-043 SHALL cover, with GHOST_IDLE_RELEASE_EN defined: level_start then no dots for 240 frames -> release=0111; 240 more frames -> release=1111.
